jk_cmd_sequencer: RTL and testbench
===================================

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO depth, power of two, minimum 2.
REQ-002 Parameter CNT_W, default 4: width of the repeat-count field.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  FIFO can accept a command this cycle.
REQ-007 cmd_op  input  2  00 hold, 01 clear, 10 set, 11 toggle.
REQ-008 cmd_cnt  input  CNT_W  repeat count; the op is driven for cmd_cnt+1 cycles.
REQ-009 q_fb  input  1  Q fed back from the downstream JK flip-flop.
REQ-010 j  output  1  registered J drive to the JK flip-flop.
REQ-011 k  output  1  registered K drive to the JK flip-flop.
REQ-012 busy  output  1  high while the sequencer is in ISSUE.
REQ-013 level  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-014 err  output  1  sticky Q-mismatch flag (see Configuration).

Function
REQ-015 A command SHALL be accepted on a posedge where cmd_valid and cmd_ready are both high, and written to the FIFO tail.
REQ-016 cmd_ready SHALL equal (level != DEPTH), derived combinationally from registered occupancy, with no dependence on a same-cycle pop.
REQ-017 There SHALL be no FIFO bypass: an accepted command is always written before it is popped.
REQ-018 The FSM SHALL have two states. IDLE: j=k=0. ISSUE: {j,k}=active op.
REQ-019 In IDLE with level>0, the next edge SHALL pop the head, load op and cnt into the active registers, set {j,k}=op, and enter ISSUE.
REQ-020 In ISSUE, a remaining-cycle counter SHALL start at cnt and decrement each edge; {j,k} SHALL be held for exactly cnt+1 cycles.
REQ-021 On the final ISSUE cycle (counter=0) with level>0, the next command SHALL be popped and driven with no idle bubble.
REQ-022 On the final ISSUE cycle with level=0, the FSM SHALL return to IDLE with j=k=0 on the next edge.
REQ-023 Latency: a command accepted at edge E0 into an empty, idle block SHALL appear on j/k after edge E1.
REQ-024 A simultaneous push and pop SHALL leave level unchanged; push-only increments level, pop-only decrements it.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH.
REQ-026 Op 00 with cnt=N SHALL produce N+1 cycles of j=k=0 with busy=1, giving a programmed delay.
REQ-027 busy SHALL be 1 exactly when the FSM is in ISSUE.

Reset
REQ-028 Asserting reset (low) SHALL immediately force IDLE, j=0, k=0, busy=0, level=0, both pointers 0, counter 0, and err=0; cmd_ready therefore reads 1.
REQ-029 Reset asserted mid-ISSUE SHALL abort the active command and discard all queued commands.
REQ-030 After deassertion, the first command SHALL be acceptable on the first clock edge.

Configuration
REQ-031 Macro JK_SEQ_CHECK_EN defined: a shadow Q register (reset 0) SHALL update each edge from the current {j,k} using JK rules (00 hold, 01 to 0, 10 to 1, 11 invert).
REQ-032 With JK_SEQ_CHECK_EN defined, err SHALL set on any edge where q_fb differs from the shadow Q, and SHALL clear only on reset.
REQ-033 Macro JK_SEQ_CHECK_EN undefined: err SHALL be constant 0, q_fb SHALL be unused, and no shadow logic SHALL be built.

Verification
REQ-034 After reset, push set cnt=2 -> j=1,k=0 for 3 cycles starting one cycle after acceptance, busy=1 for those 3 cycles, then j=k=0 and busy=0.
REQ-035 Push set cnt=0, then toggle cnt=3, back-to-back -> j/k read 10 for 1 cycle, then 11 for 4 cycles, with no idle cycle between them.
REQ-036 With DEPTH=4, push 5 commands with cnt=15 while the first is issuing -> level reaches 4, cmd_ready=0, and the 5th command is held until a pop occurs.
REQ-037 Push at full occupancy on the same cycle as a pop -> push refused (cmd_ready=0), level decrements by 1.
REQ-038 Assert reset during toggle cnt=7 with 2 commands queued -> j=k=0, level=0, busy=0 immediately; no queued command executes after release.
REQ-039 With JK_SEQ_CHECK_EN defined, drive toggle cnt=1 with q_fb tied to 0 -> err=1 after the first edge and remains 1 until reset.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// JK flip-flop command sequencer: FIFO of {op,cnt} commands replayed on j/k.
// Optional shadow-Q checker enabled by defining JK_SEQ_CHECK_EN.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_cnt,
  input  logic                     q_fb,
  output logic                     j,
  output logic                     k,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 2 + CNT_W;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       jk_q, jk_d;
  state_t           state_q, state_d;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;

  assign cmd_ready = (level_q != LW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    jk_d     = jk_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (level_q != '0) pop = 1'b1;
      end
      ISSUE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (level_q != '0) begin
          pop = 1'b1;
        end else begin
          state_d = IDLE;
          jk_d    = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
    // Pop only sees registered occupancy, so a command is never bypassed.
    if (pop) begin
      state_d  = ISSUE;
      jk_d     = head[EW-1:CNT_W];
      cnt_d    = head[CNT_W-1:0];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      jk_q     <= 2'b00;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      jk_q     <= jk_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_cnt};
  end

  assign j     = jk_q[1];
  assign k     = jk_q[0];
  assign busy  = (state_q == ISSUE);
  assign level = level_q;

`ifdef JK_SEQ_CHECK_EN
  logic shadow_q, shadow_d;
  logic err_q, err_d;

  always_comb begin
    shadow_d = shadow_q;
    unique case (jk_q)
      2'b01:   shadow_d = 1'b0;
      2'b10:   shadow_d = 1'b1;
      2'b11:   shadow_d = ~shadow_q;
      default: shadow_d = shadow_q;
    endcase
    err_d = err_q | (q_fb != shadow_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer (DEPTH=4, CNT_W=4).
// Vector table plus hand sequences for full/wrap/reset corner cases.
module tb_jk_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_cnt;
  logic       q_fb;
  logic       j, k, busy, err;
  logic [2:0] level;

  int total = 0;
  int bad   = 0;

  jk_cmd_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .level     (level),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [3:0] cnt;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [6:0] obs();
    return {j, k, busy, level, cmd_ready};
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_cnt   = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] op,
                              input logic [3:0] cnt, input logic jj,
                              input logic kk, input logic b,
                              input logic [2:0] l, input logic r);
    vec_t t;
    t.v   = v;
    t.op  = op;
    t.cnt = cnt;
    t.exp = {jj, kk, b, l, r};
    return t;
  endfunction

  logic [1:0] ops [6];
  bit         ok;

  initial begin
    q_fb = 1'b0;
    // {valid,op,cnt} driven after checking {j,k,busy,level,ready}
    tbl[0]  = mk(1, 2'b10, 4'd2, 0, 0, 0, 3'd0, 1);
    tbl[1]  = mk(0, 2'b00, 4'd0, 0, 0, 0, 3'd1, 1);
    tbl[2]  = mk(0, 2'b00, 4'd0, 1, 0, 1, 3'd0, 1);
    tbl[3]  = mk(0, 2'b00, 4'd0, 1, 0, 1, 3'd0, 1);
    tbl[4]  = mk(0, 2'b00, 4'd0, 1, 0, 1, 3'd0, 1);
    tbl[5]  = mk(1, 2'b10, 4'd0, 0, 0, 0, 3'd0, 1);
    tbl[6]  = mk(1, 2'b11, 4'd3, 0, 0, 0, 3'd1, 1);
    tbl[7]  = mk(0, 2'b00, 4'd0, 1, 0, 1, 3'd1, 1);
    tbl[8]  = mk(0, 2'b00, 4'd0, 1, 1, 1, 3'd0, 1);
    tbl[9]  = mk(0, 2'b00, 4'd0, 1, 1, 1, 3'd0, 1);
    tbl[10] = mk(0, 2'b00, 4'd0, 1, 1, 1, 3'd0, 1);
    tbl[11] = mk(0, 2'b00, 4'd0, 1, 1, 1, 3'd0, 1);
    tbl[12] = mk(0, 2'b00, 4'd0, 0, 0, 0, 3'd0, 1);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("vec%0d", i), 16'(obs()), 16'(tbl[i].exp));
      cmd_valid = tbl[i].v;
      cmd_op    = tbl[i].op;
      cmd_cnt   = tbl[i].cnt;
      step();
    end

    // Fill to DEPTH while a long command runs; pointers wrap.
    ops[0] = 2'b11; ops[1] = 2'b10; ops[2] = 2'b01;
    ops[3] = 2'b00; ops[4] = 2'b11; ops[5] = 2'b10;
    do_reset();
    cmd_valid = 1'b1; cmd_op = ops[0]; cmd_cnt = 4'd15;
    step();
    cmd_valid = 1'b0;
    step();
    chk("first_issue", 16'(obs()), 16'({2'b11, 1'b1, 3'd0, 1'b1}));
    for (int i = 1; i <= 4; i++) begin
      cmd_valid = 1'b1; cmd_op = ops[i]; cmd_cnt = 4'd15;
      step();
    end
    chk("full_level", 16'(level), 16'd4);
    chk("full_ready", 16'(cmd_ready), 16'd0);
    cmd_op = ops[5];
    ok = 1'b1;
    repeat (11) begin
      step();
      if (level !== 3'd4 || cmd_ready !== 1'b0) ok = 1'b0;
    end
    chk("held_5th", 16'(ok), 16'd1);
    chk("held_jk", 16'({j, k}), 16'(ops[0]));
    step();
    chk("pop_at_full", 16'(obs()), 16'({ops[1], 1'b1, 3'd3, 1'b1}));
    step();
    chk("5th_taken", 16'({level, cmd_ready}), 16'({3'd4, 1'b0}));
    cmd_valid = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      repeat ((i == 2) ? 15 : 16) step();
      chk($sformatf("order%0d", i), 16'({j, k, busy}),
          16'({ops[i], 1'b1}));
    end
    repeat (16) step();
    chk("drain_idle", 16'(obs()), 16'({2'b00, 1'b0, 3'd0, 1'b1}));

    // Reset mid toggle with two commands queued.
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_cnt = 4'd7;
    step();
    cmd_valid = 1'b0;
    step();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_cnt = 4'd0;
    step();
    cmd_op = 2'b01;
    step();
    cmd_valid = 1'b0;
    chk("pre_rst", 16'(obs()), 16'({2'b11, 1'b1, 3'd2, 1'b1}));
    #2 reset = 1'b0;
    #1;
    chk("async_rst", 16'(obs()), 16'({2'b00, 1'b0, 3'd0, 1'b1}));
    @(negedge clk);
    reset = 1'b1;
    ok = 1'b1;
    repeat (12) begin
      step();
      if ({j, k, busy} !== 3'b000 || level !== 3'd0) ok = 1'b0;
    end
    chk("no_replay", 16'(ok), 16'd1);

`ifdef JK_SEQ_CHECK_EN
    do_reset();
    q_fb = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_cnt = 4'd1;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    chk("err_set", 16'(err), 16'd1);
    repeat (6) step();
    chk("err_sticky", 16'(err), 16'd1);
    reset = 1'b0;
    #1;
    chk("err_rst", 16'(err), 16'd0);
    reset = 1'b1;
`else
    chk("err_off", 16'(err), 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
